alu_mul_seq: RTL and testbench

//  Iterative shift-add multiply sequencer that drives the pipeline's 64-bit ALU (opcode ADD).
//  It accepts one multiply request, then feeds the ALU op1/op2 once per cycle and accumulates its result.
//  It returns the low WIDTH bits of the product on a valid/ready response port.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_mul_seq.sv | 114 +++++++++++
 tb/tb_alu_mul_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Purpose: shared ALU opcodes and the multiply-sequencer state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] ALU_OP_ADD = 4'b0100;
    localparam logic [3:0] ALU_OP_SUB = 4'b0010;
    localparam logic [3:0] ALU_OP_CMP = 4'b1010;
    localparam logic [3:0] ALU_OP_MOV = 4'b1101;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_RUN  = 2'd1,
        MS_DONE = 2'd2
    } ms_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Purpose: iterative shift-add multiplier that borrows the shared EX-stage ALU (ADD) while busy.
// Latency: WIDTH RUN cycles after the accept cycle, rsp_valid the cycle after (fewer with early termination).
// Backpressure: one request in flight; req_ready low from accept until the product is taken on rsp_ready.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   req_valid/req_ready      request handshake carrying req_a (multiplicand), req_b (multiplier)
//   rsp_valid/rsp_ready      response handshake carrying rsp_result = (a*b) mod 2^WIDTH
//   busy                     high in RUN and DONE; EX muxes the ALU inputs to this block while set
//   alu_op1/alu_op2          ALU operands (accumulator, gated multiplicand)
//   alu_opcode/alu_set_cond  constant ADD, flags never written
//   alu_result               combinational ALU sum for the current operands
// Build option: define ALU_MUL_SEQ_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are 0.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             busy,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [3:0]       alu_opcode,
    output logic             alu_set_cond,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ms_state_t        state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;
    logic [CNT_W-1:0] cnt;
    logic             last_iter;

`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
    // Once the multiplier bits still to be consumed are all zero, further
    // iterations would only add 0, so the accumulator is already final.
    assign last_iter = (cnt == CNT_LAST) || (mplr[WIDTH-1:1] == '0);
`else
    assign last_iter = (cnt == CNT_LAST);
`endif

    // The ALU sums the accumulator with the multiplicand gated by the current
    // multiplier LSB; its carry-out is irrelevant since the product wraps.
    assign alu_op1      = acc;
    assign alu_op2      = mplr[0] ? mcand : '0;
    assign alu_opcode   = ALU_OP_ADD;
    assign alu_set_cond = 1'b0;
    assign rsp_result   = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MS_IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplr      <= '0;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                MS_IDLE: begin
                    if (req_valid) begin
                        acc       <= '0;
                        mcand     <= req_a;
                        mplr      <= req_b;
                        cnt       <= '0;
                        state     <= MS_RUN;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                MS_RUN: begin
                    acc   <= alu_result;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 1'b1;
                    if (last_iter) begin
                        state     <= MS_DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                MS_DONE: begin
                    // acc is frozen here, so rsp_result holds until taken.
                    if (rsp_ready) begin
                        state     <= MS_IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= MS_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Purpose: directed self-checking bench for alu_mul_seq; the bench also plays the shared ALU (ADD).
// Latency: expected response cycle derived from the multiplier and the build option.
// Backpressure: exercises rsp_ready stalls and req_valid held high while busy.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic        busy;
    logic [63:0] alu_op1;
    logic [63:0] alu_op2;
    logic [3:0]  alu_opcode;
    logic        alu_set_cond;
    logic [63:0] alu_result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the EX-stage ALU doing ADD.
    assign alu_result = alu_op1 + alu_op2;

    alu_mul_seq #(.WIDTH(64), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .busy         (busy),
        .alu_op1      (alu_op1),
        .alu_op2      (alu_op2),
        .alu_opcode   (alu_opcode),
        .alu_set_cond (alu_set_cond),
        .alu_result   (alu_result)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycles from the accept cycle to the first cycle showing rsp_valid.
    function automatic int exp_lat(input logic [63:0] b);
`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
        int hi;
        hi = 0;
        for (int i = 0; i < 64; i++) begin
            if (b[i]) hi = i + 1;
        end
        if (hi < 1) hi = 1;
        return hi + 1;
`else
        return 65;
`endif
    endfunction

    task automatic do_mul(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int stall, input bit spam);
        int          lat;
        bit          got;
        int          bad_const;
        int          bad_busy;
        int          bad_hold;
        logic [63:0] res;

        @(negedge clk);
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        rsp_ready = (stall == 0);
        check_eq({tag, "_req_ready_idle"}, {63'd0, req_ready}, 64'd1);

        lat       = 0;
        got       = 1'b0;
        bad_const = 0;
        bad_busy  = 0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (alu_opcode !== 4'b0100 || alu_set_cond !== 1'b0) bad_const++;
            if (req_ready !== 1'b0 || busy !== 1'b1) bad_busy++;
            if (rsp_valid === 1'b1) got = 1'b1;
            if (spam && !got) begin
                req_a = ~a;
                req_b = ~b ^ 64'h5;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check_eq({tag, "_rsp_seen"}, {63'd0, got}, 64'd1);
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat(b)));
        check_eq({tag, "_result"}, rsp_result, exp);
        check_eq({tag, "_alu_const"}, 64'(bad_const), 64'd0);
        check_eq({tag, "_busy_run"}, 64'(bad_busy), 64'd0);

        if (stall > 0) begin
            res      = rsp_result;
            bad_hold = 0;
            for (int i = 1; i < stall; i++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_result !== res || req_ready !== 1'b0) bad_hold++;
            end
            check_eq({tag, "_hold"}, 64'(bad_hold), 64'd0);
            rsp_ready = 1'b1;
        end

        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq({tag, "_idle_after"}, {61'd0, busy, req_ready, rsp_valid}, 64'b010);
    endtask

    initial begin : main
        int bad_rsp;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_op1", alu_op1, 64'd0);
        check_eq("rst_op2", alu_op2, 64'd0);
        rst = 1'b0;

        do_mul("t1_3x5", 64'd3, 64'd5, 64'd15, 0, 1'b0);
        do_mul("t2_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b0);
        do_mul("t3_stall", 64'h1234, 64'h10, 64'h12340, 10, 1'b0);

        // Reset in the middle of RUN.
        @(negedge clk);
        req_a     = 64'd7;
        req_b     = 64'd9;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (29) @(negedge clk);
        check_eq("t4_busy_before_rst", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t4_rst_req_ready", {63'd0, req_ready}, 64'd1);
        check_eq("t4_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("t4_rst_busy", {63'd0, busy}, 64'd0);
        check_eq("t4_rst_op1", alu_op1, 64'd0);
        check_eq("t4_rst_op2", alu_op2, 64'd0);
        bad_rsp = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad_rsp++;
        end
        check_eq("t4_no_rsp", 64'(bad_rsp), 64'd0);
        do_mul("t4_2x3", 64'd2, 64'd3, 64'd6, 0, 1'b0);

        do_mul("t5_spam", 64'h100, 64'h22, 64'h2200, 3, 1'b1);
        do_mul("t6_mixed", 64'hDEAD_BEEF, 64'h1_0000_0001, 64'hDEAD_BEEF_DEAD_BEEF, 0, 1'b0);
        do_mul("t7_7x2", 64'd7, 64'd2, 64'd14, 0, 1'b0);
        do_mul("t7_5x0", 64'd5, 64'd0, 64'd0, 0, 1'b0);
        do_mul("t7_top_bit", 64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
